// File: rtl/quad_gate_tester_pkg.sv
// Shared types and constants for the quad 2-input AND gate tester.
package quad_gate_test_pkg;

  localparam int VEC_W  = 8;
  localparam int ERR_W  = 9;
  localparam int LANE_W = 4;
  localparam int CNT_W  = 4;

  localparam logic [VEC_W-1:0] VEC_LAST = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // True when any returned gate output differs from the AND of its two inputs.
  function automatic logic gate_mismatch(input logic [LANE_W-1:0] a,
                                         input logic [LANE_W-1:0] b,
                                         input logic [LANE_W-1:0] y);
    return (y != (a & b));
  endfunction

endpackage

// File: rtl/quad_gate_tester_if.sv
// Control/status and gate-pin bundle between a test host and the gate tester.
interface quad_gate_tester_if;
  import quad_gate_test_pkg::*;

  logic              start;
  logic              abort;
  logic [LANE_W-1:0] a_out;
  logic [LANE_W-1:0] b_out;
  logic [LANE_W-1:0] y_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [VEC_W-1:0]  first_fail_vec;
  logic              first_fail_valid;

  // Host side: issues commands and returns the gate outputs.
  modport master (
    output start, abort, y_in,
    input  a_out, b_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  // Tester side.
  modport slave (
    input  start, abort, y_in,
    output a_out, b_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

endinterface

// File: rtl/quad_gate_tester_settle_timer.sv
// Down-counter that times how long each vector is held on the gate pins.
module settle_timer
  import quad_gate_test_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             cnt_en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Load has priority; counting stops at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/quad_gate_tester.sv
// Exhaustive tester for a quad 2-input AND: walks all 256 input vectors,
// holds each for SETTLE_CYCLES, then compares the returned outputs.
module quad_gate_tester
  import quad_gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input logic               clk,
  input logic               reset,
  quad_gate_tester_if.slave bus
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state_d, state_q;
  logic [VEC_W-1:0]  vec_d, vec_q;
  logic [LANE_W-1:0] a_out_d, a_out_q;
  logic [LANE_W-1:0] b_out_d, b_out_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              pass_d, pass_q;
  logic [ERR_W-1:0]  err_count_d, err_count_q;
  logic [VEC_W-1:0]  first_fail_vec_d, first_fail_vec_q;
  logic              first_fail_valid_d, first_fail_valid_q;

  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_zero;
  logic              mismatch;

  settle_timer u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .cnt_en   (tmr_en),
    .zero     (tmr_zero)
  );

  // The registered pin drive equals vec throughout SETTLE/CHECK, so the
  // expected response is taken from the pins themselves.
  assign mismatch = gate_mismatch(a_out_q, b_out_q, bus.y_in);

  // Next-state and next-output computation for the test sequencer.
  always_comb begin
    state_d            = state_q;
    vec_d              = vec_q;
    pass_d             = pass_q;
    err_count_d        = err_count_q;
    first_fail_vec_d   = first_fail_vec_q;
    first_fail_valid_d = first_fail_valid_q;
    tmr_load           = 1'b0;
    tmr_en             = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d            = ST_SETTLE;
          vec_d              = '0;
          tmr_load           = 1'b1;
          err_count_d        = '0;
          pass_d             = 1'b0;
          first_fail_vec_d   = '0;
          first_fail_valid_d = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else if (tmr_zero) begin
          state_d = ST_CHECK;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_CHECK: begin
        // The compare is recorded even when the run is being aborted.
        if (mismatch) begin
          err_count_d = err_count_q + ERR_W'(1);
          if (!first_fail_valid_q) begin
            first_fail_vec_d   = vec_q;
            first_fail_valid_d = 1'b1;
          end
        end
        if (bus.abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
          pass_d  = (err_count_d == '0);
        end else begin
          state_d  = ST_SETTLE;
          vec_d    = vec_q + VEC_W'(1);
          tmr_load = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are computed from the next state so they are registered and
    // line up with the state they describe.
    busy_d  = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d  = (state_d == ST_DONE);
    a_out_d = busy_d ? vec_d[LANE_W-1:0]     : '0;
    b_out_d = busy_d ? vec_d[VEC_W-1:LANE_W] : '0;
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      vec_q              <= '0;
      a_out_q            <= '0;
      b_out_q            <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      err_count_q        <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      vec_q              <= vec_d;
      a_out_q            <= a_out_d;
      b_out_q            <= b_out_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      pass_q             <= pass_d;
      err_count_q        <= err_count_d;
      first_fail_vec_q   <= first_fail_vec_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  assign bus.a_out            = a_out_q;
  assign bus.b_out            = b_out_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_count_q;
  assign bus.first_fail_vec   = first_fail_vec_q;
  assign bus.first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_quad_gate_tester.sv
// Bench for quad_gate_tester: AND-gate model with 10 ns delay and stuck-at
// fault injection; expected run results are queued and checked at done.
module tb_quad_gate_tester;
  import quad_gate_test_pkg::*;

  localparam int SC      = 4;
  localparam int RUN_CYC = 256 * (SC + 1);
  localparam int LIMIT   = RUN_CYC + 100;

  typedef struct {
    logic [8:0] err;
    logic [7:0] ffv;
    logic       ffvalid;
    logic       pass;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [3:0] gate_y;
  logic [3:0] stuck0 = 4'h0;
  logic [3:0] stuck1 = 4'h0;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  quad_gate_tester_if bus();

  quad_gate_tester #(.SETTLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign #10 gate_y = bus.a_out & bus.b_out;
  assign bus.y_in   = (gate_y & ~stuck0) | stuck1;

  // Reference: walk every vector through a faulty gate and tally mismatches.
  function automatic exp_t model_run(input logic [3:0] s0, input logic [3:0] s1);
    exp_t e;
    e.err = '0; e.ffv = '0; e.ffvalid = 1'b0;
    for (int v = 0; v < 256; v++) begin
      logic [7:0] vv;
      logic [3:0] ex, y;
      vv = 8'(v);
      ex = vv[3:0] & vv[7:4];
      y  = (ex & ~s0) | s1;
      if (y !== ex) begin
        e.err = e.err + 9'd1;
        if (!e.ffvalid) begin
          e.ffv     = vv;
          e.ffvalid = 1'b1;
        end
      end
    end
    e.pass = (e.err == 9'd0);
    return e;
  endfunction

  task automatic start_pulse();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  // Counts cycles from the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (cyc < LIMIT && !ok) begin
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_vec(input logic [7:0] v, output bit ok);
    int n;
    n = 0; ok = 1'b0;
    while (n < LIMIT && !ok) begin
      @(negedge clk);
      n++;
      if (bus.busy === 1'b1 && {bus.b_out, bus.a_out} === v) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.abort = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.a_out, bus.b_out, bus.busy, bus.done, bus.pass, bus.err_count,
         bus.first_fail_vec, bus.first_fail_valid} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs: got a=%0h b=%0h busy=%0b done=%0b pass=%0b err=%0d ffv=%0h ffvalid=%0b, want all 0",
               bus.a_out, bus.b_out, bus.busy, bus.done, bus.pass, bus.err_count,
               bus.first_fail_vec, bus.first_fail_valid);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_run(input string name, input logic [3:0] s0, input logic [3:0] s1);
    int   cyc;
    bit   ok;
    exp_t e;
    stuck0 = s0; stuck1 = s1;
    sb_q.push_back(model_run(s0, s1));
    start_pulse();
    wait_done(cyc, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || cyc != RUN_CYC) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles (done seen=%0b), want %0d", name, cyc, ok, RUN_CYC);
    end
    checks++;
    if (bus.err_count !== e.err || bus.pass !== e.pass) begin
      failures++;
      $display("FAIL %s_result: got err=%0d pass=%0b, want err=%0d pass=%0b",
               name, bus.err_count, bus.pass, e.err, e.pass);
    end
    checks++;
    if (bus.first_fail_valid !== e.ffvalid || (e.ffvalid && bus.first_fail_vec !== e.ffv)) begin
      failures++;
      $display("FAIL %s_first_fail: got valid=%0b vec=%0h, want valid=%0b vec=%0h",
               name, bus.first_fail_valid, bus.first_fail_vec, e.ffvalid, e.ffv);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.a_out !== 4'h0 || bus.b_out !== 4'h0) begin
      failures++;
      $display("FAIL %s_after_done: got done=%0b busy=%0b a=%0h b=%0h, want 0 0 0 0",
               name, bus.done, bus.busy, bus.a_out, bus.b_out);
    end
    stuck0 = 4'h0; stuck1 = 4'h0;
  endtask

  task automatic test_abort();
    bit   ok;
    int   dones;
    exp_t e;
    e.err = 9'd0; e.ffv = 8'h00; e.ffvalid = 1'b0; e.pass = 1'b0;
    sb_q.push_back(e);
    start_pulse();
    wait_vec(8'h30, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL abort_reach_vec: got timeout, want vec 30 reached");
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (bus.busy !== 1'b0 || bus.a_out !== 4'h0 || bus.b_out !== 4'h0) begin
      failures++;
      $display("FAIL abort_stop: got busy=%0b a=%0h b=%0h, want 0 0 0", bus.busy, bus.a_out, bus.b_out);
    end
    checks++;
    if (bus.pass !== e.pass || bus.err_count !== e.err || bus.first_fail_valid !== e.ffvalid) begin
      failures++;
      $display("FAIL abort_status: got pass=%0b err=%0d ffvalid=%0b, want %0b %0d %0b",
               bus.pass, bus.err_count, bus.first_fail_valid, e.pass, e.err, e.ffvalid);
    end
    dones = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    bit   ok;
    exp_t e;
    sb_q.push_back(model_run(4'h0, 4'h0));
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk);
    wait_done(cyc, ok);
    e = sb_q.pop_front();
    checks++;
    if (!ok || cyc != RUN_CYC || bus.pass !== e.pass) begin
      failures++;
      $display("FAIL b2b_first_run: got cycles=%0d pass=%0b, want %0d pass=%0b", cyc, bus.pass, RUN_CYC, e.pass);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_gap: got done=%0b busy=%0b, want 0 0", bus.done, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.err_count !== 9'd0 || bus.pass !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart: got busy=%0b done=%0b err=%0d pass=%0b, want 1 0 0 0",
               bus.busy, bus.done, bus.err_count, bus.pass);
    end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop: got busy=%0b, want 0", bus.busy);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int dones;
    stuck0 = 4'b0100;
    start_pulse();
    wait_vec(8'h80, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_reach_vec: got timeout, want vec 80 reached");
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.a_out, bus.b_out, bus.busy, bus.done, bus.pass, bus.err_count,
         bus.first_fail_vec, bus.first_fail_valid} !== 30'd0) begin
      failures++;
      $display("FAIL rst_midrun_outputs: got a=%0h b=%0h busy=%0b err=%0d ffv=%0h ffvalid=%0b, want all 0",
               bus.a_out, bus.b_out, bus.busy, bus.err_count, bus.first_fail_vec, bus.first_fail_valid);
    end
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    stuck0 = 4'h0;
    dones  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL rst_no_resume: got %0d busy/done cycles, want 0", dones);
    end
    test_run("rst_fresh", 4'h0, 4'h0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_run("good", 4'h0, 4'h0);
    test_run("y3_sa0", 4'b0100, 4'h0);
    test_run("y1_sa1", 4'h0, 4'b0001);
    test_abort();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_gate_tester.md
QUAD_GATE_TESTER -- requirements
Module: quad_gate_tester

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clock cycles each vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one full exhaustive test run; sampled only in IDLE.
REQ-005 abort  input  1  synchronous stop of a run in progress.
REQ-006 a_out  output  4  gate A inputs a1..a4 (bit0 = a1) driven to the quad 2-input AND under test.
REQ-007 b_out  output  4  gate B inputs b1..b4 (bit0 = b1).
REQ-008 y_in  input  4  gate outputs y1..y4 (bit0 = y1) returned from the device under test.
REQ-009 busy  output  1  high while a run is in SETTLE or CHECK.
REQ-010 done  output  1  one-cycle pulse at run completion; never pulses after an abort.
REQ-011 pass  output  1  high when the last completed run had zero mismatches.
REQ-012 err_count  output  9  number of failing vectors in the current or last run, 0..256.
REQ-013 first_fail_vec  output  8  first failing vector; valid when first_fail_valid = 1.
REQ-014 first_fail_valid  output  1  high once any mismatch has been recorded in the current or last run.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, CHECK and DONE.
REQ-016 An internal 8-bit vec register SHALL drive the gate inputs: a_out = vec[3:0], b_out = vec[7:4] in SETTLE and CHECK; a_out and b_out = 0 in IDLE and DONE.
REQ-017 IDLE, start=1 and abort=0 at the clock edge: next state SETTLE; vec=0; settle counter loaded with SETTLE_CYCLES-1; err_count, pass, first_fail_valid and first_fail_vec cleared.
REQ-018 SETTLE: counter decrements each cycle; at counter=0 the next state is CHECK, so SETTLE lasts exactly SETTLE_CYCLES cycles.
REQ-019 CHECK lasts one cycle: expected = a_out & b_out bitwise; a mismatch on any bit of y_in SHALL increment err_count by exactly 1.
REQ-020 On the first mismatch of a run, first_fail_vec is set to vec and first_fail_valid is set; later mismatches do not change either.
REQ-021 CHECK with vec != 255: vec increments, counter reloads, next state SETTLE. CHECK with vec = 255: next state DONE, with no wrap of vec.
REQ-022 DONE lasts one cycle: done=1; pass = (err_count==0, including the final CHECK update); next state IDLE.
REQ-023 Run latency: done SHALL be high exactly 256*(SETTLE_CYCLES+1) cycles after the edge that accepted start.
REQ-024 start is ignored in SETTLE, CHECK and DONE; a start held through DONE is accepted at the first IDLE edge.
REQ-025 abort=1 in SETTLE or CHECK: next state IDLE; no done pulse; pass=0; err_count and first_fail fields keep their partial values; a CHECK compare in that cycle is still counted.
REQ-026 abort and start high together in IDLE: abort wins and the run does not start.
REQ-027 y_in SHALL be sampled only in CHECK; its value in every other state has no effect.

Reset
REQ-028 When reset asserts, the block SHALL immediately and asynchronously enter IDLE with vec=0 and counter=0, and with every output at 0: a_out, b_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid.
REQ-029 Reset asserted mid-run SHALL discard all partial results; no done pulse follows.

Structure
REQ-030 The package quad_gate_test_pkg SHALL hold the state enum and the constants VEC_W=8, ERR_W=9 and VEC_LAST=8'hFF.
REQ-031 The settle countdown SHALL be a sub-module named settle_timer with ports load, load value, count enable and a zero flag.
REQ-032 All outputs SHALL be registered; no combinational path is allowed from y_in to any output.

Verification (clk period 10 ns, quad AND gate model with DELAY=10 ns)
REQ-033 Good gate, SETTLE_CYCLES=4, start pulse -> done exactly 1280 cycles later; pass=1; err_count=0; first_fail_valid=0; a_out=b_out=0 afterwards.
REQ-034 y3 (y_in bit2) stuck-at-0 -> err_count=64; first_fail_vec=8'h44; first_fail_valid=1; pass=0.
REQ-035 y1 (y_in bit0) stuck-at-1 -> err_count=192; first_fail_vec=8'h00; pass=0.
REQ-036 Good gate, abort while vec=8'h30 -> busy=0 and a_out=0 the next cycle; done never pulses; pass=0; err_count=0.
REQ-037 start held high for the entire run -> exactly one done pulse, then a second run begins on the cycle after DONE.
REQ-038 reset pulse at vec=8'h80 of a stuck-at run -> all outputs 0 immediately; a fresh start then completes normally after 1280 cycles.
